// File: rtl/push_button_pkg.sv
// Shared types and helpers for the push-button debouncer and later
// board-input blocks.
package push_button_pkg;

    // Debouncer FSM states: two stable states, each with a pending state
    // used while the opposite level is being confirmed.
    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } btn_state_t;

    // Pin level seen while the button is not pressed.
    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    // Width that holds the larger of two cycle counts without overflow.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with a configurable reset value, so the
// synchronised level matches the idle pin level straight out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: resetting to the idle pin level stops a spurious edge
            // from being seen when reset releases with the button untouched.
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample their
            // old values on the same edge, which is what builds the chain.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/push_button_debouncer.sv
// Push-button front end: synchronises the raw pin, debounces it and reports
// a clean pressed level plus press, release and long-press pulses.
module push_button_debouncer
    import push_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int BTN_ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst_n_async,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic long_held
);

    localparam int               CNT_W       = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] DEB_TARGET  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TARGET = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             btn_sync;
    logic             btn_s;

    btn_state_t       state_q;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             long_hit;

    logic             btn_level_q;
    logic             press_pulse_q;
    logic             release_pulse_q;
    logic             long_press_pulse_q;
    logic             long_held_q;

    sync_2ff #(
        .RESET_VAL (released_level(BTN_ACTIVE_LOW != 0))
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n_async),
        .d_i   (btn_raw),
        .q_o   (btn_sync)
    );

    // Normalise the synchronised pin so 1 always means pressed.
    assign btn_s = (BTN_ACTIVE_LOW != 0) ? ~btn_sync : btn_sync;

    // Saturating increments: the counters stick at all-ones instead of
    // wrapping, so a very long hold can never re-arm the threshold.
    assign deb_cnt_d  = (deb_cnt_q  == CNT_MAX) ? deb_cnt_q  : deb_cnt_q  + CNT_ONE;
    assign hold_cnt_d = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + CNT_ONE;

    // The long press fires on the PRESSED cycle whose increment lands on
    // the threshold, once per press.
    assign long_hit = (hold_cnt_d == LONG_TARGET) && !long_held_q;

    // Debounce FSM with its counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            state_q            <= RELEASED;
            deb_cnt_q          <= '0;
            hold_cnt_q         <= '0;
            btn_level_q        <= 1'b0;
            press_pulse_q      <= 1'b0;
            release_pulse_q    <= 1'b0;
            long_press_pulse_q <= 1'b0;
            long_held_q        <= 1'b0;
        end else begin
            press_pulse_q      <= 1'b0;
            release_pulse_q    <= 1'b0;
            long_press_pulse_q <= 1'b0;

            case (state_q)
                RELEASED: begin
                    if (btn_s) begin
                        state_q   <= PRESS_PENDING;
                        deb_cnt_q <= CNT_ONE;
                    end
                end

                PRESS_PENDING: begin
                    if (!btn_s) begin
                        // Glitch: drop back silently.
                        state_q   <= RELEASED;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DEB_TARGET) begin
                        state_q       <= PRESSED;
                        deb_cnt_q     <= '0;
                        hold_cnt_q    <= '0;
                        btn_level_q   <= 1'b1;
                        press_pulse_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_d;
                    end
                end

                PRESSED: begin
                    // Every cycle resident in PRESSED counts toward the hold,
                    // including one that sees the pin fall, so the threshold
                    // still fires if it coincides with the fall.
                    hold_cnt_q <= hold_cnt_d;
                    if (long_hit) begin
                        long_press_pulse_q <= 1'b1;
                        long_held_q        <= 1'b1;
                    end
                    if (!btn_s) begin
                        state_q   <= RELEASE_PENDING;
                        deb_cnt_q <= CNT_ONE;
                    end
                end

                RELEASE_PENDING: begin
                    // hold_cnt is frozen here.
                    if (btn_s) begin
                        // Release bounce: resume the hold, no new press.
                        state_q   <= PRESSED;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DEB_TARGET) begin
                        state_q         <= RELEASED;
                        deb_cnt_q       <= '0;
                        btn_level_q     <= 1'b0;
                        long_held_q     <= 1'b0;
                        release_pulse_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_d;
                    end
                end

                default: begin
                    state_q   <= RELEASED;
                    deb_cnt_q <= '0;
                end
            endcase
        end
    end

    assign btn_level        = btn_level_q;
    assign press_pulse      = press_pulse_q;
    assign release_pulse    = release_pulse_q;
    assign long_press_pulse = long_press_pulse_q;
    assign long_held        = long_held_q;

endmodule
